// File: rtl/axis_gen_sequencer_pkg.sv
// Shared types and constants for the axis_data_gen run controller.
// Holds the FSM state encoding, beat geometry and the packet beat-count helper.
package axis_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int PKT_LEN_W      = 16;
  localparam int DEF_DATA_WIDTH = 1024;
  localparam int BPB            = DEF_DATA_WIDTH / 8;

  // Beats needed to carry len bytes; 17 bits so len + bpb - 1 cannot wrap.
  function automatic logic [16:0] beat_count(input logic [PKT_LEN_W-1:0] len,
                                             input int bpb);
    logic [16:0] sum;
    sum = {1'b0, len} + 17'(bpb - 1);
    return sum / 17'(bpb);
  endfunction

endpackage

// File: rtl/axis_gen_sequencer_if.sv
// Config, generator-control, AXIS monitor tap and status bundle of the sequencer.
// master = sequencer side, slave = host/generator side.
interface axis_gen_sequencer_if
  import axis_gen_pkg::*;
#(
  parameter int G_CNT_WIDTH = 32
);
  logic                   cfg_start;
  logic                   cfg_stop;
  logic [PKT_LEN_W-1:0]   cfg_pkt_length;
  logic [G_CNT_WIDTH-1:0] cfg_period;
  logic [G_CNT_WIDTH-1:0] cfg_pkt_count;

  logic                   gen_enable;
  logic [PKT_LEN_W-1:0]   gen_pkt_length;
  logic [G_CNT_WIDTH-1:0] gen_period;

  logic                   mon_tvalid;
  logic                   mon_tready;
  logic                   mon_tlast;

  logic                   busy;
  logic                   done;
  logic                   err_cfg;
  logic [G_CNT_WIDTH-1:0] pkts_sent;

  modport master (
    input  cfg_start, cfg_stop, cfg_pkt_length, cfg_period, cfg_pkt_count,
    input  mon_tvalid, mon_tready, mon_tlast,
    output gen_enable, gen_pkt_length, gen_period,
    output busy, done, err_cfg, pkts_sent
  );

  modport slave (
    output cfg_start, cfg_stop, cfg_pkt_length, cfg_period, cfg_pkt_count,
    output mon_tvalid, mon_tready, mon_tlast,
    input  gen_enable, gen_pkt_length, gen_period,
    input  busy, done, err_cfg, pkts_sent
  );

endinterface

// File: rtl/axis_gen_sequencer.sv
// Run controller for axis_data_gen: validates and latches a run config, enables the
// generator, counts completed packets on the TX tap and stops on a packet boundary.
module axis_gen_sequencer
  import axis_gen_pkg::*;
#(
  parameter int G_AXIS_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int G_CNT_WIDTH       = 32
) (
  input  logic                 axis_streaming_data_clk,
  input  logic                 axis_streaming_arst,
  axis_gen_sequencer_if.master bus
);

  localparam int BEAT_BYTES = G_AXIS_DATA_WIDTH / 8;

  state_t                 state, state_nxt;
  logic                   in_pkt;
  logic [G_CNT_WIDTH-1:0] target_q;
  logic [G_CNT_WIDTH-1:0] pkts_sent_q;
  logic [PKT_LEN_W-1:0]   pkt_length_q;
  logic [G_CNT_WIDTH-1:0] period_q;
  logic                   gen_enable_q, busy_q, done_q, err_q;

  logic        eop, beat_mid;
  logic [16:0] beats;
  logic        cfg_bad, start_ok, start_bad, last_eop, drained;

  assign eop      = bus.mon_tvalid & bus.mon_tready & bus.mon_tlast;
  assign beat_mid = bus.mon_tvalid & bus.mon_tready & ~bus.mon_tlast;

  // A packet must fit strictly inside its period so the generator always has an
  // idle cycle between packets, which is what makes a one-cycle-late disable safe.
  assign beats     = beat_count(bus.cfg_pkt_length, BEAT_BYTES);
  assign cfg_bad   = (bus.cfg_pkt_length == '0) || (bus.cfg_period == '0) ||
                     (G_CNT_WIDTH'(beats) >= bus.cfg_period);
  assign start_ok  = (state == ST_IDLE) & bus.cfg_start & ~cfg_bad;
  assign start_bad = (state == ST_IDLE) & bus.cfg_start & cfg_bad;

  assign last_eop = eop && (target_q != '0) &&
                    (({1'b0, pkts_sent_q} + {{G_CNT_WIDTH{1'b0}}, 1'b1}) == {1'b0, target_q});
  assign drained  = ~in_pkt & ~bus.mon_tvalid;

  always_ff @(posedge axis_streaming_data_clk or posedge axis_streaming_arst) begin
    if (axis_streaming_arst) state <= ST_IDLE;
    else                     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok)                   state_nxt = ST_RUN;
      ST_RUN:   if (last_eop || bus.cfg_stop)   state_nxt = ST_DRAIN;
      ST_DRAIN: if (drained)                    state_nxt = ST_DONE;
      ST_DONE:                                  state_nxt = ST_IDLE;
      default:                                  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_streaming_data_clk or posedge axis_streaming_arst) begin
    if (axis_streaming_arst) begin
      in_pkt <= 1'b0;
    end else if (eop) begin
      in_pkt <= 1'b0;
    end else if (beat_mid) begin
      in_pkt <= 1'b1;
    end
  end

  // Config and count hold through IDLE so software can read the last run's result.
  always_ff @(posedge axis_streaming_data_clk or posedge axis_streaming_arst) begin
    if (axis_streaming_arst) begin
      pkt_length_q <= '0;
      period_q     <= '0;
      target_q     <= '0;
      pkts_sent_q  <= '0;
    end else if (start_ok) begin
      pkt_length_q <= bus.cfg_pkt_length;
      period_q     <= bus.cfg_period;
      target_q     <= bus.cfg_pkt_count;
      pkts_sent_q  <= '0;
    end else if ((state == ST_RUN || state == ST_DRAIN) && eop && (pkts_sent_q != '1)) begin
      pkts_sent_q  <= pkts_sent_q + 1'b1;
    end
  end

  // Status and enable are registered off the state register, one cycle behind it.
  always_ff @(posedge axis_streaming_data_clk or posedge axis_streaming_arst) begin
    if (axis_streaming_arst) begin
      gen_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      gen_enable_q <= (state == ST_RUN);
      busy_q       <= (state != ST_IDLE);
      done_q       <= (state == ST_DONE);
      err_q        <= start_bad;
    end
  end

  assign bus.gen_enable     = gen_enable_q;
  assign bus.gen_pkt_length = pkt_length_q;
  assign bus.gen_period     = period_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.err_cfg        = err_q;
  assign bus.pkts_sent      = pkts_sent_q;

endmodule

// File: tb/tb_axis_gen_sequencer.sv
// Randomized bench for axis_gen_sequencer: a behavioural axis_data_gen model feeds the
// TX tap, and runs are judged against handshake counts and the config acceptance rule.
module tb_axis_gen_sequencer;

  localparam int CW  = 32;
  localparam int BPB = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_gen_sequencer_if #(.G_CNT_WIDTH(CW)) bus ();

  axis_gen_sequencer #(.G_AXIS_DATA_WIDTH(1024), .G_CNT_WIDTH(CW)) dut (
    .axis_streaming_data_clk (clk),
    .axis_streaming_arst     (rst),
    .bus                     (bus)
  );

  int n_chk = 0, n_err = 0;
  int hs_eop = 0, n_done = 0, n_errcfg = 0;
  int done_tick = -1;
  bit bp = 1'b0;

  // generator model state
  bit g_active = 1'b0, g_hold = 1'b0;
  int g_left = 0, g_beats = 0, g_cnt = 1 << 20;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit cfg_rejected(input int len, input longint per);
    int b;
    b = (len + BPB - 1) / BPB;
    return (len == 0) || (per == 0) || (longint'(b) >= per);
  endfunction

  task automatic gen_reset();
    g_active = 0; g_hold = 0; g_left = 0; g_beats = 0; g_cnt = 1 << 20;
    bus.mon_tvalid = 0; bus.mon_tlast = 0; bus.mon_tready = 1;
  endtask

  // One clock: observe the edge, then sample outputs and drive the next inputs.
  task automatic tick();
    bit hs, last;
    @(posedge clk);
    hs   = bus.mon_tvalid & bus.mon_tready;
    last = hs & bus.mon_tlast;
    #1;
    if (last) hs_eop++;
    if (bus.done) n_done++;
    if (bus.err_cfg) n_errcfg++;
    bus.cfg_start = 0;
    bus.cfg_stop  = 0;
    if (hs) begin
      if (bus.mon_tlast) begin g_active = 0; g_hold = 1; end
      else g_left--;
    end
    g_cnt++;
    if (!g_active) begin
      if (g_hold) g_hold = 0;
      else if (bus.gen_enable && g_cnt >= int'(bus.gen_period)) begin
        g_active = 1;
        g_beats  = (int'(bus.gen_pkt_length) + BPB - 1) / BPB;
        g_left   = g_beats;
        g_cnt    = 0;
      end
    end
    bus.mon_tvalid = g_active;
    bus.mon_tlast  = g_active && (g_left == 1);
    bus.mon_tready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},   bus.gen_enable, 0);
    chk({tag, "_len"},  bus.gen_pkt_length, 0);
    chk({tag, "_per"},  bus.gen_period, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_err"},  bus.err_cfg, 0);
    chk({tag, "_pkts"}, bus.pkts_sent, 0);
  endtask

  task automatic do_start(input string tag, input int len, input longint per,
                          input longint cnt, input bit with_stop, output bit acc);
    bit rej;
    rej = cfg_rejected(len, per);
    hs_eop = 0; n_done = 0; n_errcfg = 0;
    bus.cfg_pkt_length = 16'(len);
    bus.cfg_period     = CW'(per);
    bus.cfg_pkt_count  = CW'(cnt);
    bus.cfg_start      = 1;
    bus.cfg_stop       = with_stop;
    tick();
    chk({tag, "_err_pulse"}, bus.err_cfg, rej);
    chk({tag, "_busy_n"},    bus.busy, 0);
    tick();
    if (rej) begin
      chk({tag, "_rej_busy"}, bus.busy, 0);
      chk({tag, "_rej_en"},   bus.gen_enable, 0);
      chk({tag, "_rej_errn"}, n_errcfg, 1);
    end else begin
      chk({tag, "_busy"}, bus.busy, 1);
      chk({tag, "_en"},   bus.gen_enable, 1);
      chk({tag, "_len"},  bus.gen_pkt_length, len);
      chk({tag, "_per"},  bus.gen_period, per);
      chk({tag, "_pkts0"}, bus.pkts_sent, 0);
    end
    acc = !rej;
  endtask

  // Wait for the run to finish; exp_cnt < 0 means the packet count is not fixed.
  task automatic end_run(input string tag, input int exp_cnt);
    int t = 0;
    done_tick = -1;
    while (bus.busy && t < 20000) begin
      tick();
      t++;
      if (bus.done) done_tick = t;
    end
    chk({tag, "_timeout"}, (t < 20000), 1);
    chk({tag, "_done_cnt"}, n_done, 1);
    chk({tag, "_busy_fall"}, t - done_tick, 1);
    chk({tag, "_pkts"}, bus.pkts_sent, hs_eop);
    if (exp_cnt >= 0) chk({tag, "_eops"}, hs_eop, exp_cnt);
    chk({tag, "_en_off"}, bus.gen_enable, 0);
    repeat (3) tick();
    chk({tag, "_pkts_hold"}, bus.pkts_sent, hs_eop);
  endtask

  initial begin
    bit acc;
    int t;
    bus.cfg_start = 0; bus.cfg_stop = 0;
    bus.cfg_pkt_length = 0; bus.cfg_period = 0; bus.cfg_pkt_count = 0;
    gen_reset();
    #1;
    chk_all_zero("rst");
    repeat (3) tick();
    rst = 0;
    tick();
    chk_all_zero("post_rst");

    // basic counted run
    do_start("run4", 64, 128, 4, 0, acc);
    end_run("run4", 4);

    // continuous run, stopped mid-packet after 10 packets
    do_start("cont", 1024, 20, 0, 0, acc);
    t = 0;
    while (!(hs_eop >= 10 && g_active && g_left < g_beats) && t < 5000) begin tick(); t++; end
    chk("cont_reach", (t < 5000), 1);
    bus.cfg_stop = 1;
    tick();
    end_run("cont", 11);

    // rejected configurations
    do_start("bad_len", 0, 128, 4, 0, acc);
    do_start("bad_per", 64, 0, 4, 0, acc);
    do_start("bad_beats", 1024, 8, 4, 0, acc);
    repeat (5) tick();
    chk("bad_idle_busy", bus.busy, 0);
    chk("bad_idle_en", bus.gen_enable, 0);

    // start and stop together, then a second start during the run
    do_start("both", 300, 30, 3, 1, acc);
    bus.cfg_pkt_length = 999; bus.cfg_period = 77; bus.cfg_pkt_count = 1;
    bus.cfg_start = 1;
    tick(); tick();
    chk("restart_len", bus.gen_pkt_length, 300);
    chk("restart_per", bus.gen_period, 30);
    chk("restart_err", n_errcfg, 0);
    end_run("both", 3);

    // stop coinciding with the final eop
    do_start("stop_last", 64, 16, 4, 0, acc);
    t = 0;
    while (hs_eop < 4 && t < 5000) begin
      if (bus.mon_tvalid && bus.mon_tready && bus.mon_tlast && hs_eop == 3) bus.cfg_stop = 1;
      tick();
      t++;
    end
    end_run("stop_last", 4);

    // randomized runs under backpressure
    bp = 1;
    for (int i = 0; i < 8; i++) begin
      int len, per, cnt;
      len = $urandom_range(1, 2000);
      per = $urandom_range(1, 40);
      cnt = $urandom_range(1, 5);
      do_start($sformatf("rnd%0d", i), len, per, cnt, 0, acc);
      if (acc) end_run($sformatf("rnd%0d", i), cnt);
    end
    bp = 0;

    // asynchronous reset in the middle of a run
    do_start("arst", 1024, 20, 0, 0, acc);
    repeat (25) tick();
    #2 rst = 1;
    #1;
    chk_all_zero("arst");
    gen_reset();
    repeat (2) tick();
    rst = 0;
    tick();
    do_start("after_rst", 64, 128, 3, 0, acc);
    end_run("after_rst", 3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/axis_gen_sequencer.md
# axis_gen_sequencer

Run controller for `axis_data_gen` in the 400GbE streaming TX path. It accepts a start command with packet length, period and packet count, and programs and enables the generator. It monitors the generator's AXIS output to count completed packets, then disables the generator on a packet boundary and reports completion. It is the only block that drives the generator's `axis_data_gen_enable`, `pkt_length` and `period` inputs.

## Interface
- `G_AXIS_DATA_WIDTH`, 1024, generator data width in bits; bytes per beat `BPB = G_AXIS_DATA_WIDTH/8`.
- `G_CNT_WIDTH`, 32, width of the packet-count and period fields.
- `axis_streaming_data_clk  in  1  sole clock`
- `axis_streaming_arst  in  1  reset, asynchronous, active-high`
- `cfg_start  in  1  one-cycle start pulse`
- `cfg_stop  in  1  one-cycle stop pulse`
- `cfg_pkt_length  in  16  packet length, bytes`
- `cfg_period  in  G_CNT_WIDTH  packet period, cycles`
- `cfg_pkt_count  in  G_CNT_WIDTH  packets per run; 0 = continuous`
- `gen_enable  out  1  to axis_data_gen_enable`
- `gen_pkt_length  out  16  to pkt_length`
- `gen_period  out  G_CNT_WIDTH  to period`
- `mon_tvalid, mon_tready, mon_tlast  in  1 each  tap of the generator TX AXIS`
- `busy  out  1  high in RUN/DRAIN/DONE`
- `done  out  1  one-cycle pulse at end of run`
- `err_cfg  out  1  one-cycle pulse on rejected start`
- `pkts_sent  out  G_CNT_WIDTH  completed packets this run`

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset puts the block in IDLE with every output at 0.
- Packet-end event: `eop = mon_tvalid & mon_tready & mon_tlast`.
- `in_pkt` flag:
  - Set on `mon_tvalid & mon_tready & !mon_tlast`.
  - Cleared on `eop`.
- IDLE with `cfg_start`, config validation:
  - Beat count `beats = (cfg_pkt_length + BPB - 1) / BPB`, computed at 17 bits.
  - Reject if `cfg_pkt_length == 0`, `cfg_period == 0`, or `beats >= cfg_period`.
  - On reject: pulse `err_cfg` and stay in IDLE.
  - On accept: latch `gen_pkt_length`, `gen_period` and the target count, clear `pkts_sent`, go to RUN.
- RUN:
  - `gen_enable` = 1.
  - Each `eop` increments `pkts_sent`, which saturates at all-ones.
  - If the target count is non-zero and `pkts_sent + 1 == target` on an `eop`, go to DRAIN.
  - `cfg_stop` also goes to DRAIN.
- DRAIN:
  - `gen_enable` = 0.
  - `eop` continues to be counted, because the generator may finish a packet already in flight.
  - Exit to DONE when `in_pkt == 0` and `mon_tvalid == 0` in the same cycle.
- DONE: pulse `done` for 1 cycle, then go to IDLE.
- `gen_pkt_length`, `gen_period` and `pkts_sent` hold their values in IDLE until the next accepted start.
- Ignored inputs:
  - `cfg_start` outside IDLE.
  - `cfg_stop` in IDLE or DRAIN.
  - `cfg_start` and `cfg_stop` together in IDLE: start is processed, stop is ignored.
- `cfg_stop` in the same cycle as the final `eop` in RUN: go to DRAIN once, count that packet, and produce a single `done`.
- Reset mid-run: all outputs go to 0 immediately and the FSM returns to IDLE. A partial generator packet is not tracked.

## Timing
- All outputs are registered.
- Accepted start sampled at edge N: `busy`, `gen_enable`, `gen_pkt_length` and `gen_period` are valid after edge N+1.
- `err_cfg` is high for the cycle after edge N.
- Final `eop` at edge M: `gen_enable` is 0 after M+1. This is safe because `beats < period` guarantees at least one idle cycle before the generator starts the next packet.
- DRAIN exit condition at edge K: `done` is high after K+1 and `busy` falls after K+2.
- `pkts_sent` updates 1 cycle after the `eop` that it counts.

## Structure
- Shared package `axis_gen_pkg`:
  - State enum.
  - `BPB`.
  - Packet-length width (16).
  - Beat-count function.
- No sub-module. The FSM, monitor flag and counter live in one file.

## Test plan
- Start with length 64, period 128, count 4 (1024-bit, tready=1) -> `gen_enable` high 1 cycle after start; exactly 4 `eop`; `pkts_sent` = 4; one `done`; `gen_enable` = 0 before a 5th packet begins.
- Start with count 0, then `cfg_stop` after 10 packets while mid-packet -> DRAIN until that packet's `tlast`; `pkts_sent` = 11; one `done`.
- Invalid configs: length 0; period 0; length 1024 with period 8 (8 beats >= 8) -> `err_cfg` pulse each time; `busy` stays 0; `gen_enable` stays 0.
- `cfg_start` and `cfg_stop` together in IDLE -> run starts. Second `cfg_start` during RUN -> ignored, latched config unchanged.
- `cfg_stop` in the same cycle as the 4th of 4 `eop` -> `pkts_sent` = 4, exactly one `done`. Random `mon_tready` backpressure -> count matches the number of `tlast` handshakes.
- Assert `axis_streaming_arst` during RUN -> all outputs 0 asynchronously. A subsequent valid start runs normally from `pkts_sent` = 0.
